// File: rtl/aes_stream_adapter.sv
// Word-stream front end for a block AES core: packs four input words into a block,
// runs the core with a bounded wait for its result, then streams the ciphertext back out.
module aes_stream_adapter #(
  parameter  int BLOCK_LENGTH = 128,
  parameter  int KEY_LENGTH   = 128,
  parameter  int TIMEOUT      = 64,
  localparam int WORD_W       = BLOCK_LENGTH / 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [KEY_LENGTH-1:0]   KEY,
  input  logic [WORD_W-1:0]       IN_DATA,
  input  logic                    IN_VALID,
  output logic                    IN_READY,
  output logic [WORD_W-1:0]       OUT_DATA,
  output logic                    OUT_VALID,
  input  logic                    OUT_READY,
  output logic [BLOCK_LENGTH-1:0] PT,
  output logic [KEY_LENGTH-1:0]   M_KEY,
  output logic                    En,
  input  logic [BLOCK_LENGTH-1:0] CT,
  input  logic                    Valid,
  output logic                    ERR,
  output logic [15:0]             BLK_CNT
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {COLLECT, RUN, DRAIN} state_e;

  state_e                  state_q, state_d;
  logic [1:0]              wi_q, wi_d;
  logic [1:0]              wj_q, wj_d;
  logic [TW-1:0]           tmo_q, tmo_d;
  logic [BLOCK_LENGTH-1:0] pt_q, pt_d;
  logic [KEY_LENGTH-1:0]   key_q, key_d;
  logic [BLOCK_LENGTH-1:0] buf_q, buf_d;
  logic [15:0]             blk_cnt_q, blk_cnt_d;
  logic                    err_q, err_d;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= COLLECT;
      wi_q      <= '0;
      wj_q      <= '0;
      tmo_q     <= '0;
      pt_q      <= '0;
      key_q     <= '0;
      buf_q     <= '0;
      blk_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wi_q      <= wi_d;
      wj_q      <= wj_d;
      tmo_q     <= tmo_d;
      pt_q      <= pt_d;
      key_q     <= key_d;
      buf_q     <= buf_d;
      blk_cnt_q <= blk_cnt_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    wi_d      = wi_q;
    wj_d      = wj_q;
    tmo_d     = tmo_q;
    pt_d      = pt_q;
    key_d     = key_q;
    buf_d     = buf_q;
    blk_cnt_d = blk_cnt_q;
    err_d     = 1'b0;
    IN_READY  = (state_q == COLLECT);
    OUT_VALID = (state_q == DRAIN);
    En        = (state_q == RUN);
    OUT_DATA  = buf_q[BLOCK_LENGTH-1-WORD_W*int'(wj_q) -: WORD_W];
    case (state_q)
      COLLECT: begin
        if (IN_VALID) begin
          pt_d[BLOCK_LENGTH-1-WORD_W*int'(wi_q) -: WORD_W] = IN_DATA;
          wi_d = wi_q + 2'd1;
          if (wi_q == 2'd3) begin
            key_d   = KEY;
            tmo_d   = '0;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        tmo_d = tmo_q + TW'(1);
        // A result arriving on the last allowed cycle takes priority over the timeout.
        if (Valid) begin
          buf_d     = CT;
          blk_cnt_d = blk_cnt_q + 16'd1;
          wj_d      = '0;
          state_d   = DRAIN;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = COLLECT;
        end
      end
      DRAIN: begin
        if (OUT_READY) begin
          wj_d = wj_q + 2'd1;
          if (wj_q == 2'd3) state_d = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  assign PT      = pt_q;
  assign M_KEY   = key_q;
  assign ERR     = err_q;
  assign BLK_CNT = blk_cnt_q;

endmodule

// File: tb/tb_aes_stream_adapter.sv
// Scoreboard bench for aes_stream_adapter with a behavioural AES core stand-in
// that returns the FIPS-197 ciphertext for the reference block and a keyed mix otherwise.
module tb_aes_stream_adapter;

  logic         CLK = 1'b0;
  logic         RST;
  logic [127:0] KEY;
  logic [31:0]  IN_DATA;
  logic         IN_VALID;
  logic         IN_READY;
  logic [31:0]  OUT_DATA;
  logic         OUT_VALID;
  logic         OUT_READY;
  logic [127:0] PT;
  logic [127:0] M_KEY;
  logic         En;
  logic [127:0] CT;
  logic         Valid;
  logic         ERR;
  logic [15:0]  BLK_CNT;

  aes_stream_adapter dut (
    .CLK(CLK), .RST(RST), .KEY(KEY), .IN_DATA(IN_DATA), .IN_VALID(IN_VALID),
    .IN_READY(IN_READY), .OUT_DATA(OUT_DATA), .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY), .PT(PT), .M_KEY(M_KEY), .En(En), .CT(CT),
    .Valid(Valid), .ERR(ERR), .BLK_CNT(BLK_CNT)
  );

  always #5 CLK = ~CLK;

  localparam logic [127:0] F_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] F_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] F_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] sb[$];
  int          core_lat = 3;
  bit          core_on = 1'b1;
  bit          stray = 1'b0;
  bit          err_allowed = 1'b0;
  int          err_seen = 0;
  int          run_cyc = 0;
  logic [15:0] exp_blk = 16'd0;

  function automatic logic [127:0] core_fn(input logic [127:0] p, input logic [127:0] k);
    if (p == F_PT && k == F_KEY) return F_CT;
    return {p[63:0], p[127:64]} ^ k ^ 128'h5a5a5a5a_c3c3c3c3_0f0f0f0f_96969696;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Core stand-in: Valid asserts in the RUN cycle where run_cyc reaches core_lat.
  initial begin
    Valid = 1'b0;
    CT = '0;
    forever begin
      @(posedge CLK);
      #1;
      if (En) run_cyc++;
      else run_cyc = 0;
      Valid = (En && core_on && run_cyc == core_lat) || (!En && stray);
      CT = core_fn(PT, M_KEY);
    end
  end

  // Monitor: pops expected words on each output handshake.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge CLK);
      if (OUT_VALID && IN_READY) begin
        errors++;
        $display("FAIL ready_valid_overlap: OUT_VALID=1 IN_READY=1 required not both");
      end
      if (ERR) begin
        err_seen++;
        if (!err_allowed) begin
          errors++;
          $display("FAIL unexpected_err: ERR=1 required 0");
        end
      end
      if (OUT_VALID && OUT_READY) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL spurious_out: got word %h with no expected word", OUT_DATA);
        end else begin
          e = sb.pop_front();
          if (OUT_DATA !== e) begin
            errors++;
            $display("FAIL out_word: got %h expected %h", OUT_DATA, e);
          end
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_word(input logic [31:0] w);
    bit rdy = 1'b0;
    IN_DATA = w;
    IN_VALID = 1'b1;
    for (int n = 0; n < 300; n++) begin
      @(negedge CLK);
      rdy = IN_READY;
      @(posedge CLK);
      #1;
      if (rdy) break;
    end
    IN_VALID = 1'b0;
    if (!rdy) begin
      errors++;
      $display("FAIL in_accept: word %h not accepted within budget", w);
    end
  endtask

  task automatic send_block(input logic [127:0] p, input bit expect_out, input bit gap);
    logic [127:0] c;
    c = core_fn(p, KEY);
    if (expect_out)
      for (int k = 0; k < 4; k++) sb.push_back(c[127-32*k -: 32]);
    for (int k = 0; k < 4; k++) begin
      send_word(p[127-32*k -: 32]);
      if (gap && k < 3) begin
        @(posedge CLK);
        #1;
      end
    end
  endtask

  task automatic wait_drain(input string name);
    bit done = 1'b0;
    for (int n = 0; n < 400; n++) begin
      @(negedge CLK);
      if (sb.size() == 0 && IN_READY) begin
        done = 1'b1;
        break;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s: drain not complete, %0d words pending", name, sb.size());
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic pulse_reset();
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  initial begin
    int n;
    RST = 1'b1;
    KEY = F_KEY;
    IN_DATA = '0;
    IN_VALID = 1'b0;
    OUT_READY = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    @(negedge CLK);
    chk("rst_in_ready", 128'(IN_READY), 128'd1);
    chk("rst_out_valid", 128'(OUT_VALID), 128'd0);
    chk("rst_en", 128'(En), 128'd0);
    chk("rst_err", 128'(ERR), 128'd0);
    chk("rst_blk_cnt", 128'(BLK_CNT), 128'd0);
    chk("rst_pt", PT, 128'd0);
    chk("rst_mkey", M_KEY, 128'd0);
    @(posedge CLK);
    #1;

    // FIPS-197 vector; with core_lat=3 OUT_VALID follows the 4th accept by 3 edges.
    core_lat = 3;
    send_block(F_PT, 1'b1, 1'b0);
    @(negedge CLK);
    chk("run_en", 128'(En), 128'd1);
    chk("run_pt", PT, F_PT);
    chk("run_mkey", M_KEY, F_KEY);
    chk("run_in_ready", 128'(IN_READY), 128'd0);
    n = 0;
    while (n < 50) begin
      @(posedge CLK);
      n++;
      @(negedge CLK);
      if (OUT_VALID) break;
    end
    chk("latency", 128'(n), 128'd3);
    wait_drain("fips");
    exp_blk++;
    chk("fips_blk_cnt", 128'(BLK_CNT), 128'(exp_blk));

    // Backpressure on the first ciphertext word.
    OUT_READY = 1'b0;
    send_block(F_PT, 1'b1, 1'b0);
    n = 0;
    while (n < 50 && !OUT_VALID) begin
      @(negedge CLK);
      n++;
    end
    chk("bp_valid_seen", 128'(OUT_VALID), 128'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      chk("bp_hold_data", 128'(OUT_DATA), 128'h69c4e0d8);
      chk("bp_in_ready", 128'(IN_READY), 128'd0);
    end
    @(posedge CLK);
    #1;
    OUT_READY = 1'b1;
    wait_drain("backpressure");
    exp_blk++;
    chk("bp_blk_cnt", 128'(BLK_CNT), 128'(exp_blk));

    // Core never answers: ERR after exactly 64 edges from RUN entry.
    core_on = 1'b0;
    err_allowed = 1'b1;
    err_seen = 0;
    send_block(F_PT ^ 128'h1, 1'b0, 1'b0);
    n = 0;
    while (n < 200) begin
      @(negedge CLK);
      if (ERR) break;
      @(posedge CLK);
      n++;
    end
    chk("tmo_cycles", 128'(n), 128'd64);
    chk("tmo_in_ready_err", 128'(IN_READY), 128'd1);
    @(negedge CLK);
    chk("tmo_err_one_cycle", 128'(ERR), 128'd0);
    chk("tmo_in_ready_next", 128'(IN_READY), 128'd1);
    chk("tmo_blk_cnt", 128'(BLK_CNT), 128'(exp_blk));
    chk("tmo_err_count", 128'(err_seen), 128'd1);
    @(posedge CLK);
    #1;
    err_allowed = 1'b0;
    core_on = 1'b1;

    // Valid on the last allowed RUN cycle wins over the timeout.
    core_lat = 64;
    send_block(F_PT, 1'b1, 1'b0);
    wait_drain("tmo_boundary");
    exp_blk++;
    chk("bnd_blk_cnt", 128'(BLK_CNT), 128'(exp_blk));

    // Gapped input with stray Valid during collection.
    core_lat = 2;
    stray = 1'b1;
    send_block(F_PT, 1'b1, 1'b1);
    stray = 1'b0;
    wait_drain("gapped");
    exp_blk++;
    chk("gap_blk_cnt", 128'(BLK_CNT), 128'(exp_blk));

    // Counter wrap from a preloaded value.
    force dut.blk_cnt_q = 16'hFFFE;
    @(posedge CLK);
    #1;
    release dut.blk_cnt_q;
    send_block(128'h0123456789abcdef_fedcba9876543210, 1'b1, 1'b0);
    wait_drain("wrap1");
    chk("wrap_ffff", 128'(BLK_CNT), 128'hFFFF);
    send_block(128'hdeadbeef_cafef00d_12345678_9abcdef0, 1'b1, 1'b0);
    wait_drain("wrap2");
    chk("wrap_0000", 128'(BLK_CNT), 128'h0000);

    // Reset after two words, then a fresh block.
    send_word(32'haaaa0001);
    send_word(32'haaaa0002);
    pulse_reset();
    @(negedge CLK);
    chk("mid_rst_pt", PT, 128'd0);
    chk("mid_rst_blk_cnt", 128'(BLK_CNT), 128'd0);
    @(posedge CLK);
    #1;
    send_block(128'h11111111_22222222_33333333_44444444, 1'b1, 1'b0);
    wait_drain("after_reset");
    chk("after_rst_blk_cnt", 128'(BLK_CNT), 128'd1);

    // Reset during RUN, then stray Valid must be ignored.
    core_lat = 10;
    send_block(F_PT, 1'b0, 1'b0);
    repeat (3) @(posedge CLK);
    #1;
    pulse_reset();
    stray = 1'b1;
    repeat (4) @(posedge CLK);
    #1;
    stray = 1'b0;
    @(negedge CLK);
    chk("run_rst_blk_cnt", 128'(BLK_CNT), 128'd0);
    chk("run_rst_in_ready", 128'(IN_READY), 128'd1);
    chk("run_rst_out_valid", 128'(OUT_VALID), 128'd0);
    @(posedge CLK);
    #1;
    core_lat = 1;
    send_block(F_PT, 1'b1, 1'b0);
    wait_drain("after_run_reset");
    chk("final_blk_cnt", 128'(BLK_CNT), 128'd1);

    repeat (3) @(posedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_stream_adapter.md
AES_STREAM_ADAPTER -- requirements
Module: aes_stream_adapter

Interface
REQ-001 Parameter BLOCK_LENGTH, default 128, AES block width; the word width SHALL be BLOCK_LENGTH/4.
REQ-002 Parameter KEY_LENGTH, default 128, AES key width.
REQ-003 Parameter TIMEOUT, default 64, maximum cycles to wait for the core's Valid.
REQ-004 CLK  input  1  single clock; all logic on the rising edge.
REQ-005 RST  input  1  synchronous, active-high reset.
REQ-006 KEY  input  KEY_LENGTH  master key, sampled with the 4th input word.
REQ-007 IN_DATA  input  32  plaintext word, most-significant word first.
REQ-008 IN_VALID  input  1  IN_DATA valid.
REQ-009 IN_READY  output  1  adapter accepts a word this cycle.
REQ-010 OUT_DATA  output  32  ciphertext word, most-significant word first.
REQ-011 OUT_VALID  output  1  OUT_DATA valid.
REQ-012 OUT_READY  input  1  downstream accepts OUT_DATA.
REQ-013 PT  output  BLOCK_LENGTH  plaintext to the AES core.
REQ-014 M_KEY  output  KEY_LENGTH  key to the AES core.
REQ-015 En  output  1  AES core enable.
REQ-016 CT  input  BLOCK_LENGTH  ciphertext from the AES core.
REQ-017 Valid  input  1  AES core result-valid strobe.
REQ-018 ERR  output  1  one-cycle pulse on a core timeout.
REQ-019 BLK_CNT  output  16  count of completed blocks; wraps 0xFFFF->0x0000.

Function
REQ-020 The FSM SHALL have three states: COLLECT, RUN and DRAIN. Reset state is COLLECT.
REQ-021 COLLECT:
- IN_READY=1.
- Each IN_VALID&IN_READY cycle stores IN_DATA into PT slice [127-32i:96-32i], where i is the 2-bit word index 0..3, then increments i.
- On acceptance with i=3: latch KEY into M_KEY, clear i, enter RUN.
REQ-022 RUN:
- En=1 in every RUN cycle, starting the cycle after the 4th word is accepted.
- IN_READY=0.
- PT and M_KEY SHALL be held stable.
REQ-023 RUN, Valid=1 sampled:
- Capture CT into the output buffer, enter DRAIN; En=0 from the next cycle.
- Increment BLK_CNT.
REQ-024 RUN timeout:
- A cycle counter clears on RUN entry and increments every RUN cycle.
- If TIMEOUT cycles elapse without Valid: pulse ERR for one cycle, discard the block, return to COLLECT, leave BLK_CNT unchanged.
- Valid sampled in the same cycle the counter reaches TIMEOUT SHALL win; no ERR in that case.
REQ-025 DRAIN:
- OUT_VALID=1; OUT_DATA = buffer word j (j=0 is the MS word).
- OUT_DATA SHALL hold while OUT_VALID&!OUT_READY.
- On OUT_READY, j increments; on acceptance with j=3, j clears and the FSM returns to COLLECT.
- IN_READY=0.
REQ-026 Valid outside RUN SHALL be ignored.
REQ-027 IN_VALID while IN_READY=0 SHALL not alter PT or i.
REQ-028 Minimum latency, 4th input word accepted to first OUT_VALID, SHALL be core latency + 1 cycle.
REQ-029 OUT_VALID and IN_READY SHALL never both be 1.

Reset
REQ-030 On RST=1 at a clock edge, in any state:
- State=COLLECT; i, j and the timeout counter =0.
- En=0, OUT_VALID=0, ERR=0, BLK_CNT=0, PT=0, M_KEY=0, output buffer=0.
- IN_READY=1 from the first cycle after RST deasserts.
REQ-031 Reset mid-RUN or mid-DRAIN SHALL discard the partial block with no ERR pulse; Valid arriving after reset SHALL be ignored.

Verification
REQ-032 FIPS-197 vector, with the real core attached:
- Stimulus: KEY=000102030405060708090a0b0c0d0e0f; words 00112233, 44556677, 8899aabb, ccddeeff.
- Response: OUT words 69c4e0d8, 6a7b0430, d8cdb780, 70b4c55a; BLK_CNT=1.
REQ-033 Backpressure: hold OUT_READY=0 for 5 cycles in DRAIN -> OUT_DATA stable at 69c4e0d8, IN_READY=0; release -> remaining 3 words in order.
REQ-034 Timeout: core model never asserts Valid -> ERR pulses exactly TIMEOUT=64 cycles after RUN entry, IN_READY=1 next cycle, BLK_CNT unchanged.
REQ-035 Reset: assert RST after 2 of 4 words, then send a full fresh block -> output equals that block's ciphertext only.
REQ-036 Gapped input (IN_VALID toggling each cycle) plus stray Valid during COLLECT -> same ciphertext as REQ-032, no spurious OUT_VALID.
REQ-037 Wrap: preload via 65536 blocks (or force) -> BLK_CNT 0xFFFF then 0x0000.
